// File: rtl/ram_2w2r.sv
// rtl/ram_2w2r.sv - two-write/two-read RAM with pending write stage; RAM_2W2R_BYPASS_EN selects write-first reads
module ram_2w2r #(
    parameter int WIDTH  = 8,
    parameter int DEEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DEEPTH-1:0] write_addr_A,
    input  logic [DEEPTH-1:0] write_addr_B,
    input  logic [WIDTH-1:0]  write_data_A,
    input  logic [WIDTH-1:0]  write_data_B,
    input  logic              write_EN_A,
    input  logic              write_EN_B,
    input  logic [DEEPTH-1:0] read_addr_0,
    input  logic [DEEPTH-1:0] read_addr_1,
    input  logic              read_EN_0,
    input  logic              read_EN_1,
    output logic [WIDTH-1:0]  read_data_0,
    output logic [WIDTH-1:0]  read_data_1,
    output logic              write_conflict
);
    localparam int WORDS = 1 << DEEPTH;

    logic [WIDTH-1:0]  mem [WORDS];
    logic              pa_valid, pb_valid;
    logic [DEEPTH-1:0] pa_addr, pb_addr;
    logic [WIDTH-1:0]  pa_data, pb_data;
    logic              collide;

    assign collide = write_EN_A && write_EN_B && (write_addr_A == write_addr_B);

    // Lowest priority source is assigned first; each later match overrides it.
    function automatic logic [WIDTH-1:0] newest(input logic [DEEPTH-1:0] addr);
        logic [WIDTH-1:0] val;
        val = mem[addr];
        if (pb_valid && pb_addr == addr) val = pb_data;
        if (pa_valid && pa_addr == addr) val = pa_data;
`ifdef RAM_2W2R_BYPASS_EN
        if (write_EN_B && write_addr_B == addr) val = write_data_B;
        if (write_EN_A && write_addr_A == addr) val = write_data_A;
`else
`endif
        return val;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pa_valid       <= 1'b0;
            pb_valid       <= 1'b0;
            read_data_0    <= '0;
            read_data_1    <= '0;
            write_conflict <= 1'b0;
        end else begin
            pa_valid       <= write_EN_A;
            pb_valid       <= write_EN_B && !collide;
            write_conflict <= collide;
            if (write_EN_A) begin
                pa_addr <= write_addr_A;
                pa_data <= write_data_A;
            end
            if (write_EN_B) begin
                pb_addr <= write_addr_B;
                pb_data <= write_data_B;
            end
            if (read_EN_0) read_data_0 <= newest(read_addr_0);
            if (read_EN_1) read_data_1 <= newest(read_addr_1);
        end
    end

    // Pending entries are dropped, not committed, on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (pb_valid) mem[pb_addr] <= pb_data;
            if (pa_valid) mem[pa_addr] <= pa_data;
        end
    end
endmodule

// File: doc/ram_2w2r.md
# ram_2w2r

Two-write, two-read synchronous RAM with write-first forwarding, fixed port-A write priority and a registered write-collision flag. It extends the 2-write/1-read register-file RAM with a second independent read port, a synchronous active-low reset for its control state, and a compile-time choice between write-first and read-first read semantics. It is used as the CPU register file and scratch store, where two pipeline stages write and two operand fetches read in the same cycle.

## Interface
Parameters:
- WIDTH, 8, data bits per word
- DEEPTH, 8, address bits; array holds 2^DEEPTH words

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active low (one clock; reset is synchronous and active-low)
- write_addr_A, write_addr_B  in  DEEPTH  write addresses
- write_data_A, write_data_B  in  WIDTH  write data
- write_EN_A, write_EN_B  in  1  write requests
- read_addr_0, read_addr_1  in  DEEPTH  read addresses
- read_EN_0, read_EN_1  in  1  read enables
- read_data_0, read_data_1  out  WIDTH  registered read data
- write_conflict  out  1  registered flag: A and B wrote the same address on the previous edge

## Operation
- Write pipeline, two stages. Edge n captures each enabled request into a pending register (valid, addr, data). Edge n+1 commits each valid pending entry to the array and clears or reloads the pending register.
- Collision: if write_EN_A and write_EN_B are both 1 and the addresses are equal, B is dropped at capture (its pending valid stays 0); write_conflict <= 1 on that edge, otherwise 0.
- Read, per port independently: at an edge with read_EN_x=1, read_data_x is loaded with the newest value for read_addr_x. Priority, highest first: current-cycle write A, current-cycle write B, pending A, pending B, array. The A/B ordering only matters at equal addresses, so it stays consistent with the collision rule.
- read_EN_x=0: read_data_x holds its value.
- Both read ports may use the same address as each other or as either write; there are no stalls and no busy states.
- Reset (rst_n=0 at an edge):
  - read_data_0, read_data_1 and write_conflict go to 0; pending valids are cleared.
  - Writes and reads presented in that cycle are ignored.
  - Pending writes captured before reset are discarded and never committed.
  - Array contents are not cleared.

## Timing
- Read latency is 1 edge. Data is valid after the edge that sampled read_EN_x and holds until the next enabled edge.
- A write presented before edge n is returned by any read sampled at edge n or later, with no gap while it sits in the pending stage.
- Array commit happens at edge n+1. It is invisible externally except through the reset-discard rule.
- Back-to-back writes to one address (same or different port) on consecutive edges: the later one wins. The current cycle overrides pending, and pending overrides the array.
- write_conflict is a single-cycle pulse, aligned with the read data of the same edge.

## Configuration
- RAM_2W2R_BYPASS_EN defined: write-first behaviour as above. A read sampled at the same edge as a matching write returns the new data.
- RAM_2W2R_BYPASS_EN undefined: read-first behaviour. The current-cycle write terms are removed from the priority chain; a same-edge read returns pending-or-array data (the old value). Forwarding from the pending stage is retained, so the write is visible from edge n+1 onward. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 edges with write_EN_A=1 (addr 0x10, data 0x55) → read_data_0/1=0 and write_conflict=0. After release, reading 0x10 does not return 0x55 unless it was written after reset.
- Same-edge bypass: write A 0x3C←0xA5 with read_EN_0=1 and read_addr_0=0x3C → read_data_0=0xA5 after that edge (0x00 or the old value when the macro is undefined). On the next edge, 0xA5 under both configurations.
- Collision: write A and B both to 0x07, with A=0x11 and B=0x22 → write_conflict=1 for one cycle. Reads of 0x07 on that edge and on the following 3 edges return 0x11.
- Dual write, dual read: A 0x01←0x9A and B 0x02←0x6B, with port 0 reading 0x01 and port 1 reading 0x02 on the same edge → 0x9A and 0x6B. Swap the read addresses one edge later → 0x6B and 0x9A.
- Consecutive writes: A 0x40←0x12 at edge n, B 0x40←0x34 at n+1, A 0x40←0x56 at n+2 → reads at n+1, n+2 and n+3 return 0x34, 0x56, 0x56. Hold behaviour: with read_EN=0 afterwards, output stays 0x56.
- Reset mid-write: A 0x20←0xEE at edge n, rst_n=0 at n+1 → a read of 0x20 after reset returns the pre-write array value, not 0xEE.
